drom_readout_seq: RTL and testbench
===================================

Name: drom_readout_seq

Overview:
- Address sequencer directly upstream of the select-decode ROM in the TDC48 readout path.
- On a start pulse it walks the 5-bit decode address from 0 to N_WORDS-1 and waits for the decoded source to settle.
- It captures the selected 16-bit word from the shared readout data bus and hands each word and its address to the host link over a valid/ready handshake.
- Between scans it parks the address at IDLE_ADDR so that no select line is active.

Parameters:
- N_WORDS, 24, number of addresses scanned per start (1..31).
- IDLE_ADDR, 31, parked address; decodes to no select asserted.
- SETTLE_CYCLES, 2, clk cycles from address change to valid rd_data (ROM register plus mux register); range 1..7.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle scan request; ignored unless idle.
- abort  in  1  terminate scan at the next clk edge.
- address  out  5  decode address to the select ROM.
- rd_data  in  16  readout bus driven by the source selected by address.
- out_data  out  16  captured word.
- out_addr  out  5  address the captured word came from.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  host link accepts the word.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at normal scan completion.

Behaviour:
- Reset values (registered, synchronous):
  - address=IDLE_ADDR
  - out_data=0, out_addr=0
  - out_valid=0, busy=0, done=0
  - state=IDLE, settle counter=0
- FSM states:
  - IDLE: address=IDLE_ADDR, busy=0. start=1 -> ISSUE with word index idx=0.
  - ISSUE: address<=idx, settle counter<=SETTLE_CYCLES-1 -> SETTLE.
  - SETTLE: decrement the counter each cycle; at 0 -> CAPTURE.
  - CAPTURE: out_data<=rd_data, out_addr<=idx, out_valid<=1 -> HOLD.
  - HOLD: stay while out_valid=1 and out_ready=0. On out_ready=1: out_valid<=0. If idx=N_WORDS-1, go to IDLE, set address<=IDLE_ADDR and pulse done for one cycle. Otherwise idx<=idx+1 and go to ISSUE.
- Timing:
  - rd_data is sampled exactly SETTLE_CYCLES+1 cycles after the address changes.
  - Minimum per-word period with out_ready tied high is SETTLE_CYCLES+3 cycles.
  - Full scan minimum is N_WORDS*(SETTLE_CYCLES+3) cycles from start to done.
- Handshake:
  - out_data and out_addr stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without acceptance, except on abort or rst.
  - out_ready while out_valid=0 is ignored.
- busy=1 in every state except IDLE; it deasserts in the same cycle done pulses.
- A start pulse while busy is ignored; it is not queued.
- abort (any non-IDLE state) has priority over every transition. At the next edge: state=IDLE, address=IDLE_ADDR, out_valid=0, no done pulse. Captured out_data is retained.
- abort and start asserted in the same cycle while in IDLE: abort wins and the scan does not start.
- rst has priority over abort and start. Mid-scan rst returns every output to its reset value at the next edge.
- Width and range rules:
  - idx is 5 bits and never exceeds N_WORDS-1; no wrap-around to IDLE_ADDR during a scan.
  - N_WORDS=31 is legal (addresses 0..30).
  - IDLE_ADDR must not lie in 0..N_WORDS-1; the bench checks this with an assertion.

Decomposition:
- Shared package tdc_readout_pkg holds:
  - ADDR_W=5, DATA_W=16, default IDLE_ADDR=31.
  - Address-map constants: ADDR_COUNTERS_BASE=0, ADDR_VERS, ADDR_DAC1, ADDR_FPGASEL, ADDR_PENCODER.
  - The FSM state enumeration.
- No sub-module; the settle counter and FSM live in one module.
- The bench instantiates this block in front of the existing select-decode ROM and a behavioural rd_data mux.

Test Plan:
- Reset and idle: hold rst for 3 cycles, then idle 10 cycles -> address=31, out_valid=0, busy=0, done=0 throughout.
- Full scan, out_ready=1, SETTLE_CYCLES=2, rd_data=0xA500+address -> 24 words in order, out_addr 0..23, out_data 0xA500..0xA517, each word 5 cycles apart. done pulses once at cycle 120 after start; address returns to 31.
- Backpressure: out_ready=0 for 7 cycles on word 5 -> out_valid held and out_data=0xA505 stable for 7 cycles; address stays 5 with no advance; the scan then completes with 24 words total.
- Abort at word 10 while in SETTLE -> next edge: address=31, busy=0, out_valid=0, no done. A subsequent start restarts from address 0.
- start pulses at words 3 and 15 during a scan, plus simultaneous start and abort in IDLE -> no restart or duplicate scan; exactly 24 words and one done; the simultaneous case leaves busy=0.
- Synchronous rst while out_valid=1 on word 8 -> next edge: all outputs equal their reset values. A new start runs a clean 24-word scan.

Source files
------------

// File: rtl/tdc_readout_pkg.sv
// Shared definitions for the TDC48 readout path: bus widths, address map
// and the readout sequencer state encoding.
package tdc_readout_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;

  localparam logic [ADDR_W-1:0] DEFAULT_IDLE_ADDR = 5'd31;

  // Select-decode ROM address map; counters occupy the low addresses.
  localparam logic [ADDR_W-1:0] ADDR_COUNTERS_BASE = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_VERS          = 5'd20;
  localparam logic [ADDR_W-1:0] ADDR_DAC1          = 5'd21;
  localparam logic [ADDR_W-1:0] ADDR_FPGASEL       = 5'd22;
  localparam logic [ADDR_W-1:0] ADDR_PENCODER      = 5'd23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/drom_readout_seq.sv
// Walks the select-decode address range, waits for the selected source to
// settle on rd_data, and hands each captured word to the host link.
module drom_readout_seq
  import tdc_readout_pkg::*;
#(
  parameter int                N_WORDS       = 24,
  parameter logic [ADDR_W-1:0] IDLE_ADDR     = DEFAULT_IDLE_ADDR,
  parameter int                SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      address_q   <= IDLE_ADDR;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      address_q   <= address_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Abort overrides every transition, including a start seen in IDLE.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (start) state_d = ST_ISSUE;
        ST_ISSUE:   state_d = ST_SETTLE;
        ST_SETTLE:  if (cnt_q == '0) state_d = ST_CAPTURE;
        ST_CAPTURE: state_d = ST_HOLD;
        ST_HOLD:    if (out_ready) state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_ISSUE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d       = idx_q;
    address_d   = address_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    if (abort) begin
      // The last captured word stays readable after an abort.
      address_d   = IDLE_ADDR;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          address_d = IDLE_ADDR;
          if (start) idx_d = '0;
        end
        ST_ISSUE: begin
          address_d = idx_q;
          cnt_d     = SETTLE_INIT;
        end
        ST_SETTLE: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
        ST_CAPTURE: begin
          out_data_d  = rd_data;
          out_addr_d  = idx_q;
          out_valid_d = 1'b1;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              address_d = IDLE_ADDR;
              done_d    = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: address_d = IDLE_ADDR;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign address   = address_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_drom_readout_seq.sv
// Bench for the readout sequencer: behavioural rd_data source, a
// transaction-level reference model, and directed scan scenarios.
module tb_drom_readout_seq;
  import tdc_readout_pkg::*;

  localparam int                TB_N_WORDS   = 24;
  localparam logic [ADDR_W-1:0] TB_IDLE_ADDR = 5'd31;
  localparam int                TB_SETTLE    = 2;

  logic              clk = 1'b0;
  logic              rst, start, abort, out_ready;
  logic [ADDR_W-1:0] address, out_addr;
  logic [DATA_W-1:0] rd_data, out_data;
  logic              out_valid, busy, done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  drom_readout_seq #(
    .N_WORDS      (TB_N_WORDS),
    .IDLE_ADDR    (TB_IDLE_ADDR),
    .SETTLE_CYCLES(TB_SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .address  (address),
    .rd_data  (rd_data),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  // Source side: ROM output register, then the mux register onto rd_data.
  logic [ADDR_W-1:0] sel_q = '0;
  logic [DATA_W-1:0] rd_q  = '0;
  always @(posedge clk) begin
    sel_q <= address;
    rd_q  <= (sel_q == TB_IDLE_ADDR) ? 16'h0000 : (16'hA500 + {11'd0, sel_q});
  end
  assign rd_data = rd_q;

  initial assert (TB_IDLE_ADDR >= TB_N_WORDS)
    else $error("IDLE_ADDR %0d lies inside the scanned range", TB_IDLE_ADDR);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: expected busy/done, word order and hold stability.
  bit   chk_en = 0, exp_busy = 0, exp_done = 0, rst_chk = 0, hold_chk = 0;
  int   exp_idx = 0;
  int   words_seen = 0;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_addr;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        if (!exp_busy) begin
          check("idle_address", address, TB_IDLE_ADDR);
          check("idle_valid", out_valid, 0);
        end
        if (rst_chk) begin
          check("rst_out_data", out_data, 0);
          check("rst_out_addr", out_addr, 0);
        end
        if (hold_chk) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, hold_data);
          check("hold_addr", out_addr, hold_addr);
        end
      end
      exp_done = 0; rst_chk = 0; hold_chk = 0;
      if (rst) begin
        exp_busy = 0; rst_chk = 1; chk_en = 1;
      end else if (!exp_busy) begin
        if (start && !abort) begin exp_busy = 1; exp_idx = 0; end
      end else if (abort) begin
        exp_busy = 0;
      end else if (out_valid && out_ready) begin
        check("word_addr", out_addr, exp_idx);
        check("word_data", out_data, 16'hA500 + exp_idx);
        words_seen = words_seen + 1;
        if (exp_idx == TB_N_WORDS - 1) begin exp_busy = 0; exp_done = 1; end
        else exp_idx = exp_idx + 1;
      end else if (out_valid) begin
        hold_chk = 1; hold_data = out_data; hold_addr = out_addr;
      end
    end
  end

  // Runs one scan; negative word arguments disable the corresponding event.
  task automatic scan(input int bp_word, input int abort_word, input int rst_word,
                      input int st_a, input int st_b,
                      output int cycles, output bit got_done, output int first_valid);
    bit stop;
    int bp_left;
    int bp_held;
    cycles = 0; got_done = 0; first_valid = -1; stop = 0; bp_left = 7; bp_held = 0;
    start = 1;
    @(posedge clk); #1 start = 0;
    while (!stop && cycles < 1000) begin
      @(posedge clk); #1;
      cycles = cycles + 1;
      start = 0;
      if (abort) begin
        abort = 0;
        check("abort_address", address, TB_IDLE_ADDR);
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 0);
        check("abort_keeps_data", out_data, 16'hA500 + abort_word - 1);
        stop = 1;
      end else if (rst) begin
        rst = 0;
        check("rst_address", address, TB_IDLE_ADDR);
        check("rst_data", out_data, 0);
        check("rst_oaddr", out_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        stop = 1;
      end else if (done) begin
        got_done = 1;
        check("done_parks_address", address, TB_IDLE_ADDR);
        stop = 1;
      end else begin
        out_ready = 1;
        if (out_valid && first_valid < 0) first_valid = cycles;
        if (out_valid && out_addr == bp_word && bp_left > 0) begin
          out_ready = 0;
          bp_left = bp_left - 1;
          bp_held = bp_held + 1;
          check("bp_address", address, bp_word);
          check("bp_data", out_data, 16'hA500 + bp_word);
        end
        if (busy && !out_valid && address == abort_word) abort = 1;
        if (out_valid && out_addr == rst_word) begin rst = 1; out_ready = 0; end
        if (out_valid && (out_addr == st_a || out_addr == st_b)) start = 1;
      end
    end
    check("scan_terminated", stop, 1);
    if (bp_word >= 0) check("bp_held_cycles", bp_held, 7);
    out_ready = 1;
  endtask

  int cyc, fv, w0;
  bit gd;

  initial begin
    rst = 1; start = 0; abort = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_addr31", address, 31);
      check("idle_busy0", busy, 0);
      check("idle_done0", done, 0);
    end

    w0 = words_seen;
    scan(-1, -1, -1, -1, -1, cyc, gd, fv);
    check("scan1_cycles", cyc, 120);
    check("scan1_done", gd, 1);
    check("scan1_first_valid", fv, 4);
    check("scan1_words", words_seen - w0, 24);

    w0 = words_seen;
    scan(5, -1, -1, -1, -1, cyc, gd, fv);
    check("bp_cycles", cyc, 127);
    check("bp_done", gd, 1);
    check("bp_words", words_seen - w0, 24);

    w0 = words_seen;
    scan(-1, 10, -1, -1, -1, cyc, gd, fv);
    check("abort_no_done", gd, 0);
    check("abort_words", words_seen - w0, 10);
    repeat (4) @(posedge clk);
    #1 check("abort_stays_idle", busy, 0);
    w0 = words_seen;
    scan(-1, -1, -1, -1, -1, cyc, gd, fv);
    check("restart_cycles", cyc, 120);
    check("restart_words", words_seen - w0, 24);

    w0 = words_seen;
    scan(-1, -1, -1, 3, 15, cyc, gd, fv);
    check("dupstart_cycles", cyc, 120);
    check("dupstart_done", gd, 1);
    repeat (10) @(posedge clk);
    #1 check("dupstart_words", words_seen - w0, 24);
    check("dupstart_idle", busy, 0);
    start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    check("start_abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 check("start_abort_addr", address, 31);

    w0 = words_seen;
    scan(-1, -1, 8, -1, -1, cyc, gd, fv);
    check("rst_no_done", gd, 0);
    check("rst_words", words_seen - w0, 8);
    w0 = words_seen;
    scan(-1, -1, -1, -1, -1, cyc, gd, fv);
    check("post_rst_cycles", cyc, 120);
    check("post_rst_words", words_seen - w0, 24);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
